// File: rtl/or1200_fwd_pkg.sv
// Shared definitions for the operand forwarding-select logic: select codes,
// address widths, the per-stage tracking record and the hit test.
package or1200_fwd_pkg;

    localparam int AW   = 5;
    localparam int SELW = 2;

    // Operand mux select codes, shared with the operand muxes themselves
    localparam logic [SELW-1:0] SEL_RF      = 2'd0;
    localparam logic [SELW-1:0] SEL_IMM     = 2'd1;
    localparam logic [SELW-1:0] SEL_EX_FORW = 2'd2;
    localparam logic [SELW-1:0] SEL_WB_FORW = 2'd3;

    // What we remember about the instruction occupying a pipeline stage
    typedef struct packed {
        logic          valid;
        logic          rfwb;
        logic          is_load;
        logic [AW-1:0] rd;
    } stage_t;

    // A stage "hits" a source when it will write that register; r0 never hits
    function automatic logic stage_hit(input stage_t stg, input logic [AW-1:0] addr);
        return stg.valid && stg.rfwb && (stg.rd == addr) && (addr != {AW{1'b0}});
    endfunction

endpackage

// File: rtl/or1200_fwd_cmp.sv
// Compares one source operand against the EX and WB producers and returns
// the select code for its operand mux. EX is checked first because it holds
// the youngest producer of any register.
module or1200_fwd_cmp
    import or1200_fwd_pkg::*;
(
    input  logic [AW-1:0]   src_addr,
    input  logic            src_used,
    input  logic            use_imm,
    input  stage_t          ex_stage,
    input  stage_t          wb_stage,
    output logic [SELW-1:0] sel
);

    // Priority select: immediate, then unused source, then EX, then WB
    always_comb begin
        sel = SEL_RF;
        if (use_imm) begin
            sel = SEL_IMM;
        end else if (!src_used) begin
            sel = SEL_RF;
        end else if (stage_hit(ex_stage, src_addr)) begin
            sel = SEL_EX_FORW;
        end else if (stage_hit(wb_stage, src_addr)) begin
            sel = SEL_WB_FORW;
        end else begin
            sel = SEL_RF;
        end
    end

endmodule

// File: rtl/or1200_fwd_sel.sv
// Forwarding-select and load-use hazard unit. Tracks the EX and WB
// destinations, registers the operand mux selects on every ID->EX transfer
// and requests a one-bubble stall when an ID source depends on a load in EX.
module or1200_fwd_sel #(
    parameter int AW   = 5,
    parameter int SELW = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_freeze,
    input  logic            ex_freeze,
    input  logic            id_valid,
    input  logic [AW-1:0]   id_rfa_addr,
    input  logic [AW-1:0]   id_rfb_addr,
    input  logic            id_rfa_used,
    input  logic            id_rfb_used,
    input  logic            id_imm_b,
    input  logic            id_rfwb,
    input  logic [AW-1:0]   id_rd_addr,
    input  logic            id_is_load,
    output logic [SELW-1:0] sel_a,
    output logic [SELW-1:0] sel_b,
    output logic            load_stall
);

    import or1200_fwd_pkg::stage_t;
    import or1200_fwd_pkg::stage_hit;
    import or1200_fwd_pkg::SEL_RF;

    stage_t          ex_r;
    stage_t          wb_r;
    stage_t          id_stage_s;
    logic [SELW-1:0] sel_a_r;
    logic [SELW-1:0] sel_b_r;
    logic [SELW-1:0] nxt_sel_a_s;
    logic [SELW-1:0] nxt_sel_b_s;
    logic            load_stall_s;
    logic            accept_s;

    or1200_fwd_cmp u_cmp_a (
        .src_addr (id_rfa_addr),
        .src_used (id_rfa_used),
        .use_imm  (1'b0),
        .ex_stage (ex_r),
        .wb_stage (wb_r),
        .sel      (nxt_sel_a_s)
    );

    or1200_fwd_cmp u_cmp_b (
        .src_addr (id_rfb_addr),
        .src_used (id_rfb_used),
        .use_imm  (id_imm_b),
        .ex_stage (ex_r),
        .wb_stage (wb_r),
        .sel      (nxt_sel_b_s)
    );

    // Load-use hazard: a load in EX cannot forward yet, so a consumer must wait
    always_comb begin
        load_stall_s = 1'b0;
        if (id_valid && ex_r.valid && ex_r.is_load) begin
            load_stall_s = (id_rfa_used && stage_hit(ex_r, id_rfa_addr)) ||
                           (id_rfb_used && !id_imm_b && stage_hit(ex_r, id_rfb_addr));
        end else begin
            load_stall_s = 1'b0;
        end
    end

    // Decide whether ID moves into EX and build the record it would carry
    always_comb begin
        accept_s           = id_valid && !id_freeze && !load_stall_s;
        id_stage_s         = '0;
        id_stage_s.valid   = 1'b1;
        id_stage_s.rfwb    = id_rfwb;
        id_stage_s.is_load = id_is_load;
        id_stage_s.rd      = id_rd_addr;
    end

    // Stage tracking and select registers; everything holds while EX is frozen
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_r    <= '0;
            wb_r    <= '0;
            sel_a_r <= SEL_RF;
            sel_b_r <= SEL_RF;
        end else if (!ex_freeze) begin
            wb_r <= ex_r;
            if (accept_s) begin
                ex_r    <= id_stage_s;
                sel_a_r <= nxt_sel_a_s;
                sel_b_r <= nxt_sel_b_s;
            end else begin
                ex_r    <= '0;
                sel_a_r <= SEL_RF;
                sel_b_r <= SEL_RF;
            end
        end else begin
            ex_r    <= ex_r;
            wb_r    <= wb_r;
            sel_a_r <= sel_a_r;
            sel_b_r <= sel_b_r;
        end
    end

    assign sel_a      = sel_a_r;
    assign sel_b      = sel_b_r;
    assign load_stall = load_stall_s;

endmodule

// File: tb/tb_or1200_fwd_sel.sv
// Directed bench for or1200_fwd_sel. Each row drives one cycle of ID/freeze
// inputs and queues the outputs expected mid-cycle: the selects registered
// at the start of the cycle and the combinational stall for these inputs.
// A separate monitor pops and compares on every falling edge.
module tb_or1200_fwd_sel;

    logic       clk;
    logic       rst;
    logic       id_freeze;
    logic       ex_freeze;
    logic       id_valid;
    logic [4:0] id_rfa_addr;
    logic [4:0] id_rfb_addr;
    logic       id_rfa_used;
    logic       id_rfb_used;
    logic       id_imm_b;
    logic       id_rfwb;
    logic [4:0] id_rd_addr;
    logic       id_is_load;
    logic [1:0] sel_a;
    logic [1:0] sel_b;
    logic       load_stall;

    typedef struct {
        int         row;
        logic [1:0] ea;
        logic [1:0] eb;
        logic       es;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   row_no   = 0;

    or1200_fwd_sel #(.AW(5), .SELW(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .id_freeze   (id_freeze),
        .ex_freeze   (ex_freeze),
        .id_valid    (id_valid),
        .id_rfa_addr (id_rfa_addr),
        .id_rfb_addr (id_rfb_addr),
        .id_rfa_used (id_rfa_used),
        .id_rfb_used (id_rfb_used),
        .id_imm_b    (id_imm_b),
        .id_rfwb     (id_rfwb),
        .id_rd_addr  (id_rd_addr),
        .id_is_load  (id_is_load),
        .sel_a       (sel_a),
        .sel_b       (sel_b),
        .load_stall  (load_stall)
    );

    // Free-running clock, 10 time units per cycle
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of stimulus, queue its expectation, then step one clock
    task automatic cyc(input logic r, input logic exf, input logic idf, input logic v,
                       input logic [4:0] ra, input logic ua, input logic [4:0] rb,
                       input logic ub, input logic imm, input logic wbw,
                       input logic [4:0] rd, input logic ld,
                       input logic [1:0] ea, input logic [1:0] eb, input logic es);
        exp_t e;
        rst         = r;
        ex_freeze   = exf;
        id_freeze   = idf;
        id_valid    = v;
        id_rfa_addr = ra;
        id_rfa_used = ua;
        id_rfb_addr = rb;
        id_rfb_used = ub;
        id_imm_b    = imm;
        id_rfwb     = wbw;
        id_rd_addr  = rd;
        id_is_load  = ld;
        row_no++;
        e.row = row_no;
        e.ea  = ea;
        e.eb  = eb;
        e.es  = es;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare DUT outputs against the oldest queued expectation
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_checks++;
            if (sel_a !== e.ea) begin
                n_errors++;
                $display("FAIL row%0d sel_a: got %0d expected %0d", e.row, sel_a, e.ea);
            end
            n_checks++;
            if (sel_b !== e.eb) begin
                n_errors++;
                $display("FAIL row%0d sel_b: got %0d expected %0d", e.row, sel_b, e.eb);
            end
            n_checks++;
            if (load_stall !== e.es) begin
                n_errors++;
                $display("FAIL row%0d load_stall: got %0d expected %0d", e.row, load_stall, e.es);
            end
        end
    end

    initial begin
        rst = 1'b1; ex_freeze = 1'b0; id_freeze = 1'b0; id_valid = 1'b0;
        id_rfa_addr = 5'd0; id_rfb_addr = 5'd0; id_rfa_used = 1'b0; id_rfb_used = 1'b0;
        id_imm_b = 1'b0; id_rfwb = 1'b0; id_rd_addr = 5'd0; id_is_load = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        //   rst   exf   idf   v     ra     ua    rb     ub    imm   wb    rd     ld    ea     eb     es
        // reset state, then back-to-back ALU dependency
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 2'd0, 2'd0, 1'b0); // 1 idle
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 5'd1,  1'b1, 5'd2,  1'b1, 1'b0, 1'b1, 5'd3,  1'b0, 2'd0, 2'd0, 1'b0); // 2 I1 -> r3
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 5'd3,  1'b1, 5'd4,  1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 2'd0, 2'd0, 1'b0); // 3 I2 reads r3
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 5'd3,  1'b1, 5'd0,  1'b0, 1'b0, 1'b1, 5'd6,  1'b0, 2'd2, 2'd0, 1'b0); // 4 I3 reads r3, -> r6
        // load-use: one stall, bubble with RF selects, retry forwards from WB
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 5'd6,  1'b1, 5'd0,  1'b0, 1'b0, 1'b1, 5'd5,  1'b1, 2'd3, 2'd0, 1'b0); // 5 load r5, reads r6
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 5'd2,  1'b1, 5'd5,  1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 2'd2, 2'd0, 1'b1); // 6 I4 reads r5: stall
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 5'd2,  1'b1, 5'd5,  1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 2'd0, 2'd0, 1'b0); // 7 I4 retry
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 2'd0, 2'd3, 1'b0); // 8 idle
        // immediate priority over a load hit, unused source A, then r0
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 5'd9,  1'b1, 2'd0, 2'd0, 1'b0); // 9 load r9
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 5'd9,  1'b0, 5'd9,  1'b1, 1'b1, 1'b0, 5'd0,  1'b0, 2'd0, 2'd0, 1'b0); // 10 imm, rfb=r9
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 5'd0,  1'b0, 2'd0, 2'd1, 1'b0); // 11 writes r0
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 5'd0,  1'b1, 5'd0,  1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 2'd0, 2'd0, 1'b0); // 12 reads r0
        // double hit: EX wins
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 5'd7,  1'b0, 2'd0, 2'd0, 1'b0); // 13 A -> r7
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 5'd7,  1'b1, 5'd0,  1'b0, 1'b0, 1'b1, 5'd7,  1'b0, 2'd0, 2'd0, 1'b0); // 14 B -> r7
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 5'd7,  1'b1, 5'd7,  1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 2'd2, 2'd0, 1'b0); // 15 C reads r7 x2
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 5'd7,  1'b1, 5'd7,  1'b1, 1'b0, 1'b1, 5'd8,  1'b0, 2'd2, 2'd2, 1'b0); // 16 D reads r7, -> r8
        // ex_freeze for three cycles holds everything
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 5'd8,  1'b1, 5'd8,  1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 2'd3, 2'd3, 1'b0); // 17 E reads r8
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 5'd8,  1'b1, 5'd8,  1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 2'd2, 2'd2, 1'b0); // 18 F frozen
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 5'd8,  1'b1, 5'd8,  1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 2'd2, 2'd2, 1'b0); // 19 F frozen
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 5'd8,  1'b1, 5'd8,  1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 2'd2, 2'd2, 1'b0); // 20 F frozen
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 5'd8,  1'b1, 5'd8,  1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 2'd2, 2'd2, 1'b0); // 21 F released
        // id_freeze alone inserts a bubble
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 5'd10, 1'b1, 5'd0,  1'b0, 1'b0, 1'b1, 5'd10, 1'b0, 2'd3, 2'd3, 1'b0); // 22 G held
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 5'd10, 1'b1, 5'd0,  1'b0, 1'b0, 1'b1, 5'd10, 1'b0, 2'd0, 2'd0, 1'b0); // 23 G released
        // reset with a load in EX and a stall pending
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 5'd10, 1'b1, 5'd0,  1'b0, 1'b0, 1'b1, 5'd11, 1'b1, 2'd0, 2'd0, 1'b0); // 24 H load r11
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 5'd11, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 2'd2, 2'd0, 1'b1); // 25 J stalls, rst
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 5'd11, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 2'd0, 2'd0, 1'b0); // 26 J after reset
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 2'd0, 2'd0, 1'b0); // 27 idle
        // bounded drain of the scoreboard
        for (int i = 0; i < 10; i++) begin
            if (sb_q.size() != 0) @(posedge clk);
        end
        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
